// File: rtl/psum_ddr_writeback.sv
// Drains each systolic unit's Psum FIFO one burst at a time and saturates lanes to 16 bits.
// The packed words are buffered locally, then written to DDR as one burst.
module psum_ddr_writeback #(
    parameter int UNIT_NUM   = 4,
    parameter int LANE_NUM   = 4,
    parameter int LANE_IN_W  = 20,
    parameter int LANE_OUT_W = 16,
    parameter int PSUM_W     = 80,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SIZE  = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int BURST_LEN  = 64,
    parameter int PSUM_DEPTH = 256
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  i_wb_start,
    input  logic [ADDR_SIZE-1:0]  i_wb_base_addr,
    output logic                  o_wb_busy,
    output logic                  o_wb_done,
    output logic                  o_wb_err,
    output logic [UNIT_NUM-1:0]   o_PsumFIFO_Grant,
    output logic                  o_PsumFIFO_Valid,
    input  logic [PSUM_W-1:0]     i_PsumFIFO_Data,
    output logic [DATA_WIDTH-1:0] burst_write_data,
    output logic [ADDR_SIZE-1:0]  burst_write_addr,
    output logic [LEN_WIDTH-1:0]  burst_write_len,
    output logic                  burst_write_req,
    input  logic                  burst_write_valid,
    input  logic                  burst_write_finish
);

    localparam int BURSTS_PER_UNIT = PSUM_DEPTH / BURST_LEN;
    localparam int PTR_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W   = $clog2(BURST_LEN + 1);
    localparam int UNIT_W  = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;
    localparam int BURST_W = (BURSTS_PER_UNIT > 1) ? $clog2(BURSTS_PER_UNIT) : 1;

    localparam logic signed [LANE_IN_W-1:0] SAT_HI = LANE_IN_W'((1 << (LANE_OUT_W - 1)) - 1);
    localparam logic signed [LANE_IN_W-1:0] SAT_LO = LANE_IN_W'(-(1 << (LANE_OUT_W - 1)));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CAPT,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t                 state, state_nx;
    logic [ADDR_SIZE-1:0]   base_addr;
    logic [UNIT_W-1:0]      unit;
    logic [BURST_W-1:0]     burst;
    logic [PTR_W-1:0]       drain_cnt;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       vld_cnt;
    logic [CNT_W-1:0]       seen_nx;
    logic                   take;
    logic                   err;
    logic                   vld_p1;
    logic [DATA_WIDTH-1:0]  word_p1;
    logic [DATA_WIDTH-1:0]  wb_buf [BURST_LEN];
    logic [ADDR_SIZE-1:0]   burst_idx;

    function automatic logic signed [LANE_OUT_W-1:0] sat_lane(input logic signed [LANE_IN_W-1:0] v);
        if (v > SAT_HI)
            return {1'b0, {(LANE_OUT_W-1){1'b1}}};
        else if (v < SAT_LO)
            return {1'b1, {(LANE_OUT_W-1){1'b0}}};
        else
            return v[LANE_OUT_W-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pack_beat(input logic [PSUM_W-1:0] beat);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < LANE_NUM; i++)
            w[i*LANE_OUT_W +: LANE_OUT_W] = sat_lane(beat[i*LANE_IN_W +: LANE_IN_W]);
        return w;
    endfunction

    always_ff @(posedge s_clk) begin
        if (!s_rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        o_wb_busy        = 1'b0;
        o_wb_done        = 1'b0;
        o_PsumFIFO_Grant = '0;
        o_PsumFIFO_Valid = 1'b0;
        burst_write_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_wb_start)
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_wb_busy        = 1'b1;
                o_PsumFIFO_Grant = UNIT_NUM'(1) << unit;
                o_PsumFIFO_Valid = 1'b1;
                if (drain_cnt == PTR_W'(BURST_LEN - 1))
                    state_nx = ST_CAPT;
            end
            ST_CAPT: begin
                o_wb_busy = 1'b1;
                state_nx  = ST_WRITE;
            end
            ST_WRITE: begin
                o_wb_busy       = 1'b1;
                burst_write_req = 1'b1;
                if (burst_write_finish)
                    state_nx = ST_NEXT;
            end
            ST_NEXT: begin
                o_wb_busy = 1'b1;
                if (burst == BURST_W'(BURSTS_PER_UNIT - 1) && unit == UNIT_W'(UNIT_NUM - 1))
                    state_nx = ST_DONE;
                else
                    state_nx = ST_DRAIN;
            end
            ST_DONE: begin
                o_wb_done = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Valids past a full burst are dropped so rd_ptr and the error check see exactly BURST_LEN.
    assign take    = (state == ST_WRITE) && burst_write_valid && (vld_cnt < CNT_W'(BURST_LEN));
    assign seen_nx = vld_cnt + CNT_W'(take);

    always_ff @(posedge s_clk) begin
        if (!s_rst) begin
            unit      <= '0;
            burst     <= '0;
            drain_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vld_cnt   <= '0;
            err       <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= o_PsumFIFO_Valid;
            if (vld_p1)
                wr_ptr <= wr_ptr + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (i_wb_start) begin
                        err       <= 1'b0;
                        unit      <= '0;
                        burst     <= '0;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= (drain_cnt == PTR_W'(BURST_LEN - 1)) ? '0 : drain_cnt + 1'b1;
                end
                ST_WRITE: begin
                    if (take) begin
                        vld_cnt <= seen_nx;
                        if (rd_ptr != PTR_W'(BURST_LEN - 1))
                            rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (burst_write_finish) begin
                        rd_ptr  <= '0;
                        wr_ptr  <= '0;
                        vld_cnt <= '0;
                        if (seen_nx < CNT_W'(BURST_LEN))
                            err <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (burst == BURST_W'(BURSTS_PER_UNIT - 1)) begin
                        burst <= '0;
                        unit  <= (unit == UNIT_W'(UNIT_NUM - 1)) ? '0 : unit + 1'b1;
                    end else begin
                        burst <= burst + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (state == ST_IDLE && i_wb_start)
            base_addr <= i_wb_base_addr;
    end

    // p1: beat arrives one cycle after its Valid; saturate, pack and store.
    assign word_p1 = pack_beat(i_PsumFIFO_Data);

    always_ff @(posedge s_clk) begin
        if (vld_p1)
            wb_buf[wr_ptr] <= word_p1;
    end

    assign burst_idx        = ADDR_SIZE'(unit) * ADDR_SIZE'(BURSTS_PER_UNIT) + ADDR_SIZE'(burst);
    assign burst_write_addr = (state == ST_WRITE) ? base_addr + burst_idx * ADDR_SIZE'(BURST_LEN) : '0;
    assign burst_write_data = wb_buf[rd_ptr];
    assign burst_write_len  = LEN_WIDTH'(BURST_LEN);
    assign o_wb_err         = err;

endmodule

// File: tb/tb_psum_ddr_writeback.sv
// Directed bench: models the Psum FIFOs and the DDR burst-write port, scoreboards every stored word.
module tb_psum_ddr_writeback;

    logic        s_clk;
    logic        s_rst;
    logic        i_wb_start;
    logic [31:0] i_wb_base_addr;
    logic        o_wb_busy;
    logic        o_wb_done;
    logic        o_wb_err;
    logic [3:0]  o_PsumFIFO_Grant;
    logic        o_PsumFIFO_Valid;
    logic [79:0] i_PsumFIFO_Data;
    logic [63:0] burst_write_data;
    logic [31:0] burst_write_addr;
    logic [9:0]  burst_write_len;
    logic        burst_write_req;
    logic        burst_write_valid;
    logic        burst_write_finish;

    psum_ddr_writeback dut (
        .s_clk              (s_clk),
        .s_rst              (s_rst),
        .i_wb_start         (i_wb_start),
        .i_wb_base_addr     (i_wb_base_addr),
        .o_wb_busy          (o_wb_busy),
        .o_wb_done          (o_wb_done),
        .o_wb_err           (o_wb_err),
        .o_PsumFIFO_Grant   (o_PsumFIFO_Grant),
        .o_PsumFIFO_Valid   (o_PsumFIFO_Valid),
        .i_PsumFIFO_Data    (i_PsumFIFO_Data),
        .burst_write_data   (burst_write_data),
        .burst_write_addr   (burst_write_addr),
        .burst_write_len    (burst_write_len),
        .burst_write_req    (burst_write_req),
        .burst_write_valid  (burst_write_valid),
        .burst_write_finish (burst_write_finish)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int total = 0;
    int bad   = 0;

    int rd_cnt, cnt, burst_num, done_cnt, early_burst;
    bit bp_mode, sat_mode, in_burst, req_prev, fin_sent;
    logic [31:0] base_exp;
    logic [63:0] w_b3, w_first;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] beat(input int k);
        logic [19:0] l;
        l = 20'(k);
        if (sat_mode)
            return {20'h01234, 20'hFFFFB, 20'h80000, 20'h7FFFF};
        return {l, l, l, l};
    endfunction

    function automatic logic [63:0] exp_word(input int k);
        logic [15:0] l;
        l = 16'(k);
        if (sat_mode)
            return 64'h1234_FFFB_8000_7FFF;
        return {l, l, l, l};
    endfunction

    // Psum FIFO model: a Valid cycle returns the next beat one cycle later
    initial begin
        bit pend;
        int kk;
        i_PsumFIFO_Data = 80'hDEAD_BEEF_0BAD_F00D_CAFE;
        forever begin
            @(negedge s_clk);
            pend = o_PsumFIFO_Valid && s_rst;
            kk   = rd_cnt;
            if (pend) begin
                chk("grant", 64'(o_PsumFIFO_Grant), 64'(1 << (rd_cnt / 256)));
                rd_cnt++;
            end
            @(posedge s_clk);
            #1;
            i_PsumFIFO_Data = pend ? beat(kk) : 80'hDEAD_BEEF_0BAD_F00D_CAFE;
        end
    end

    // DDR burst-write model
    initial begin
        int lim;
        burst_write_valid  = 1'b0;
        burst_write_finish = 1'b0;
        fin_sent = 1'b0;
        forever begin
            @(posedge s_clk);
            #1;
            burst_write_valid  = 1'b0;
            burst_write_finish = 1'b0;
            if (!burst_write_req) begin
                fin_sent = 1'b0;
            end else if (!fin_sent) begin
                lim = (burst_num == early_burst) ? 10 : 64;
                if (cnt >= lim) begin
                    burst_write_finish = 1'b1;
                    fin_sent = 1'b1;
                end else if (!bp_mode || $urandom_range(0, 2) == 0) begin
                    burst_write_valid = 1'b1;
                end
            end
        end
    end

    // Scoreboard
    initial begin
        forever begin
            @(negedge s_clk);
            if (!s_rst) begin
                cnt      = 0;
                in_burst = 1'b0;
                req_prev = 1'b0;
            end else begin
                if (burst_write_req) begin
                    chk("overlap", 64'(o_PsumFIFO_Grant), 64'd0);
                    if (!req_prev) begin
                        chk("addr", 64'(burst_write_addr), 64'(base_exp + 32'(64 * burst_num)));
                        chk("len", 64'(burst_write_len), 64'd64);
                        in_burst = 1'b1;
                    end
                end
                if (in_burst)
                    chk("req_hold", 64'(burst_write_req), 64'd1);
                if (burst_write_valid && burst_write_req) begin
                    chk("wdata", burst_write_data, exp_word(burst_num * 64 + cnt));
                    if (burst_num == 3 && cnt == 0) w_b3 = burst_write_data;
                    if (burst_num == 0 && cnt == 0) w_first = burst_write_data;
                    cnt++;
                end
                if (burst_write_finish && burst_write_req) begin
                    burst_num++;
                    cnt      = 0;
                    in_burst = 1'b0;
                end
                if (o_wb_done) done_cnt++;
                req_prev = burst_write_req;
            end
        end
    end

    task automatic start_run(input logic [31:0] b);
        rd_cnt    = 0;
        cnt       = 0;
        burst_num = 0;
        done_cnt  = 0;
        in_burst  = 1'b0;
        req_prev  = 1'b0;
        base_exp  = b;
        @(posedge s_clk);
        #1;
        i_wb_start     = 1'b1;
        i_wb_base_addr = b;
        @(posedge s_clk);
        #1;
        i_wb_start = 1'b0;
        @(negedge s_clk);
        chk("lat_valid", 64'(o_PsumFIFO_Valid), 64'd1);
        chk("err_clr", 64'(o_wb_err), 64'd0);
        chk("busy_run", 64'(o_wb_busy), 64'd1);
    endtask

    task automatic finish_run(input bit exp_err);
        int n;
        n = 0;
        do begin
            @(negedge s_clk);
            n++;
        end while (!o_wb_done && n < 20000);
        chk("done_seen", 64'(o_wb_done), 64'd1);
        chk("busy_at_done", 64'(o_wb_busy), 64'd0);
        repeat (3) @(negedge s_clk);
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("bursts", 64'(burst_num), 64'd16);
        chk("busy_after", 64'(o_wb_busy), 64'd0);
        chk("err", 64'(o_wb_err), 64'(exp_err));
    endtask

    initial begin
        int n;
        early_burst    = -1;
        bp_mode        = 1'b0;
        sat_mode       = 1'b0;
        rd_cnt         = 0;
        cnt            = 0;
        burst_num      = 0;
        done_cnt       = 0;
        base_exp       = '0;
        i_wb_start     = 1'b0;
        i_wb_base_addr = '0;
        s_rst          = 1'b0;
        repeat (3) @(posedge s_clk);
        #1;
        chk("rst_busy", 64'(o_wb_busy), 64'd0);
        chk("rst_done", 64'(o_wb_done), 64'd0);
        chk("rst_err", 64'(o_wb_err), 64'd0);
        chk("rst_grant", 64'(o_PsumFIFO_Grant), 64'd0);
        chk("rst_valid", 64'(o_PsumFIFO_Valid), 64'd0);
        chk("rst_req", 64'(burst_write_req), 64'd0);
        chk("rst_addr", 64'(burst_write_addr), 64'd0);
        s_rst = 1'b1;

        // full nominal run
        start_run(32'h1000);
        finish_run(1'b0);
        chk("b3w0", w_b3, 64'h00C0_00C0_00C0_00C0);

        // lane saturation
        sat_mode = 1'b1;
        start_run(32'h4000);
        finish_run(1'b0);
        chk("sat_word", w_first, 64'h1234_FFFB_8000_7FFF);
        sat_mode = 1'b0;

        // DDR backpressure
        bp_mode = 1'b1;
        start_run(32'h1000);
        finish_run(1'b0);
        bp_mode = 1'b0;

        // early finish on burst 2
        early_burst = 2;
        start_run(32'h3000);
        finish_run(1'b1);
        repeat (5) @(negedge s_clk);
        chk("err_sticky", 64'(o_wb_err), 64'd1);
        early_burst = -1;

        // reset in the middle of burst 5
        start_run(32'h5000);
        n = 0;
        while (!(burst_num == 5 && in_burst && cnt >= 3) && n < 20000) begin
            @(negedge s_clk);
            n++;
        end
        chk("reach_b5", 64'(n < 20000), 64'd1);
        @(posedge s_clk);
        #3;
        s_rst = 1'b0;
        @(posedge s_clk);
        #3;
        chk("mr_req", 64'(burst_write_req), 64'd0);
        chk("mr_grant", 64'(o_PsumFIFO_Grant), 64'd0);
        chk("mr_valid", 64'(o_PsumFIFO_Valid), 64'd0);
        chk("mr_busy", 64'(o_wb_busy), 64'd0);
        s_rst = 1'b1;
        start_run(32'h5000);
        finish_run(1'b0);

        // start pulse while draining is ignored
        start_run(32'h2000);
        n = 0;
        while (!o_PsumFIFO_Valid && n < 1000) begin
            @(negedge s_clk);
            n++;
        end
        @(posedge s_clk);
        #1;
        i_wb_start     = 1'b1;
        i_wb_base_addr = 32'h9000;
        @(posedge s_clk);
        #1;
        i_wb_start = 1'b0;
        finish_run(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_ddr_writeback.md
Name: psum_ddr_writeback

Overview:
Write-back engine that drains partial sums from the SystolicArray Psum FIFOs and stores them to DDR through the burst-write port of the DDR controller (ddr_sim_spikformer in simulation). It is the write-side counterpart of weight_fifo_v1, which uses the burst-read port. Per systolic unit it grants that unit's Psum FIFO and reads one burst worth of beats. Each beat holds four 20-bit signed lanes; each lane is saturated to 16 bits and the four results packed into one DDR word. The packed words are buffered locally and written as one DDR burst. It is triggered by SystolicController after i_Finish_Calc.

Parameters:
UNIT_NUM, 4, number of systolic units (matches SYSTOLIC_UNIT_NUM)
LANE_NUM, 4, lanes per Psum beat
LANE_IN_W, 20, signed width of each Psum lane
LANE_OUT_W, 16, signed width of each stored lane
PSUM_W, 80, Psum beat width (LANE_NUM*LANE_IN_W)
DATA_WIDTH, 64, DDR word width (LANE_NUM*LANE_OUT_W)
ADDR_SIZE, 32, DDR word address width
LEN_WIDTH, 10, burst length field width
BURST_LEN, 64, words per DDR burst (also local buffer depth)
PSUM_DEPTH, 256, beats per unit per run (must be a multiple of BURST_LEN)

Ports:
s_clk  in  1  clock
s_rst  in  1  synchronous reset, active-low
i_wb_start  in  1  one-cycle start pulse
i_wb_base_addr  in  ADDR_SIZE  DDR word base address, sampled on an accepted start
o_wb_busy  out  1  high from an accepted start until done
o_wb_done  out  1  one-cycle pulse when the last burst finishes
o_wb_err  out  1  sticky burst-length error flag, cleared by the next accepted start
o_PsumFIFO_Grant  out  UNIT_NUM  one-hot Psum FIFO select
o_PsumFIFO_Valid  out  1  Psum FIFO read enable
i_PsumFIFO_Data  in  PSUM_W  Psum beat, valid one cycle after the matching Valid
burst_write_data  out  DATA_WIDTH  word at the buffer read pointer (combinational, show-ahead)
burst_write_addr  out  ADDR_SIZE  burst start address
burst_write_len  out  LEN_WIDTH  burst length, constant BURST_LEN
burst_write_req  out  1  burst request
burst_write_valid  in  1  DDR consumes burst_write_data this cycle
burst_write_finish  in  1  burst complete pulse

Behaviour:
- Reset (s_rst low at a clock edge): FSM=IDLE; all outputs 0 (busy, done, err, Grant, Valid, req, addr; data reads buffer entry 0). Pointers and counters are cleared. Reset has priority in every state, including mid-burst; req drops at that same edge.
- FSM states:
  - IDLE: on i_wb_start, latch the base address, clear err, set busy, unit=0, burst=0, go to DRAIN. A start pulse outside IDLE is ignored.
  - DRAIN: Grant=one-hot(unit) and Valid=1 for exactly BURST_LEN consecutive cycles.
  - CAPT: one extra cycle for the last beat to arrive; Grant and Valid are 0.
  - WRITE: req=1, addr = base + (unit*PSUM_DEPTH/BURST_LEN + burst)*BURST_LEN. req is held until burst_write_finish.
  - NEXT: increment burst. When burst wraps at PSUM_DEPTH/BURST_LEN, set burst=0 and increment unit. If unit wraps at UNIT_NUM, go to DONE; otherwise go to DRAIN.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Capture: the beat appearing one cycle after a Valid cycle is written at the buffer write pointer. Pack lane i = sat(data[20i+19:20i]) into bits [16i+15:16i].
- Saturation: a signed lane value > 32767 stores 0x7FFF; < -32768 stores 0x8000; otherwise the low 16 bits are stored unchanged.
- Write handshake:
  - burst_write_data always shows buffer[rd_ptr].
  - Each cycle with burst_write_valid high increments rd_ptr. Gaps in valid are allowed and data holds during them.
  - valid beyond BURST_LEN beats is ignored; rd_ptr saturates at BURST_LEN-1.
  - finish in WRITE: req=0 at the next edge, go to NEXT, reset both pointers.
  - finish with fewer than BURST_LEN valids seen: set err and still proceed.
  - valid or finish outside WRITE is ignored.
- Timing:
  - Start latency: first Grant/Valid in the cycle after the start edge.
  - A nominal burst takes BURST_LEN+1 cycles of drain plus the DDR burst time, plus one NEXT cycle.
  - Grant is never asserted while req is high: drain and write never overlap.

Test Plan:
- Full run, base=0x1000, beat = {k,k,k,k} for k = 0..1023 per beat index, DDR always valid → 16 bursts at addr 0x1000 + 64n (n = 0..15); word 0 of burst 3 = 0x00C0_00C0_00C0_00C0; o_wb_done pulses once; busy low after done.
- Saturation: lanes 0x7FFFF, 0x80000, 0xFFFFB, 0x01234 → stored word 0x1234_FFFB_8000_7FFF.
- Backpressure: burst_write_valid 1-of-3 cycles pseudo-random → data sequence identical to the first scenario; req held high throughout each burst; no data lost or duplicated.
- Early finish after 10 valids → o_wb_err=1 and stays high; the run completes; the next start clears err.
- Reset low during WRITE of burst 5 → req, Grant, Valid, busy all 0 after the edge; a new start produces a clean run from burst 0 with correct addresses.
- i_wb_start pulsed during DRAIN → ignored; the burst count stays 16 and o_wb_done pulses exactly once.
